xbar_port_scheduler: RTL and testbench
======================================

// Module: xbar_port_scheduler
// PURPOSE
//  Time-shares the single shared crossbar bus among NPORTS router_port instances.
//  Each cycle it picks at most one port with a non-empty input FIFO, round-robin.
//  It drives that port's dir_incoming high (send); every other port is held at 0 (receive).
//  Grants are bounded bursts, separated by a drain gap that flushes the port's 2-stage read pipeline.
// PARAMETERS
//  NPORTS        4  number of router_port instances on the bus (>=2)
//  MAX_BURST     4  max GRANT cycles per tenure (>=1)
//  DRAIN_CYCLES  2  bus-quiet cycles after a tenure (>=1; >= port rd->valid latency)
//  IDW           $clog2(NPORTS) width of grant_id
// PORTS
//  clk            in   1       clock
//  reset          in   1       synchronous, active-high reset
//  enable         in   1       0 = no new grants; a tenure in progress completes normally
//  in_fifo_empty  in   NPORTS  per-port input-FIFO empty; request[i] = ~in_fifo_empty[i]
//  bus_stall      in   1       sink cannot accept; preempts the current tenure
//  dir_out        out  NPORTS  one-hot or zero; drives router_port dir_incoming
//  grant_valid    out  1       1 while state is SETUP or GRANT
//  grant_id       out  IDW     index of the current/last granted port
//  busy           out  1       state != IDLE
//  tenure_cnt     out  16      completed tenures, wraps at 2^16
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: dir_out=0, grant_valid=0, grant_id=0, busy=0, tenure_cnt=0,
//    rr_ptr=NPORTS-1 (port 0 has first priority), state=IDLE.
//  - IDLE: if enable && |req, winner = first requester searching rr_ptr+1 upward, modulo NPORTS.
//    At the next edge: grant_id=winner, dir_out=1<<winner, state=SETUP. Otherwise stay in IDLE.
//  - SETUP (1 cycle): turnaround while the port samples dir; go to GRANT, beat_cnt=0.
//  - GRANT: beat_cnt increments each cycle with !in_fifo_empty[grant_id] && !bus_stall.
//    Exits to DRAIN, with dir_out=0 at that edge, when any of these hold:
//    (a) bus_stall=1
//    (b) in_fifo_empty[grant_id]=1
//    (c) a beat is counted with beat_cnt==MAX_BURST-1
//  - DRAIN: dir_out=0 for exactly DRAIN_CYCLES cycles, then IDLE.
//    On the DRAIN->IDLE edge: rr_ptr=grant_id and tenure_cnt++.
//  - Per-tenure cycle budget (no stall, requester stays non-empty): 1 IDLE + 1 SETUP + MAX_BURST GRANT + DRAIN_CYCLES.
//  - rr_ptr wrap-around: from NPORTS-1, the search starts at port 0.
//  - Simultaneous requests: only round-robin order decides; no port wins twice while another requested continuously.
//  - Requester empties during SETUP: enters GRANT, exits to DRAIN on the first GRANT cycle; still counts as a tenure.
//  - enable deasserted mid-tenure: tenure finishes; IDLE then holds until enable=1.
//  - reset mid-tenure: all state returns to reset values at that edge; no drain is performed.
//  - beat_cnt width is $clog2(MAX_BURST+1) and saturates, never wraps.
//  - Invariant: $onehot0(dir_out) in every cycle. dir_out!=0 only in SETUP/GRANT.
// STRUCTURE
//  - Shared package noc_pkg: state enum (IDLE, SETUP, GRANT, DRAIN) and sched_state_t typedef;
//    default NPORTS, MAX_BURST and DRAIN_CYCLES constants.
//  - One sub-module, rr_pick: combinational rotate-priority-encoder (req, ptr -> found, idx).
//    Reusable by later output-port arbiters.
//  - FSM, counters and output registers live in xbar_port_scheduler.
// TESTING  (NPORTS=4, MAX_BURST=4, DRAIN_CYCLES=2)
//  1. Reset; port 2 alone holds 10 words ->
//     dir_out=4'b0100 for 5 cycles, 0 for 3 cycles, repeated; tenure_cnt=3 after 3 tenures.
//  2. Ports 0,1,3 non-empty from reset -> grant_id sequence 0,1,3,0,1,3;
//     dir_out never has >1 bit set.
//  3. rr_ptr=3, ports 0 and 3 request -> port 0 granted first (wrap), then port 3.
//  4. bus_stall=1 on the 2nd GRANT cycle of port 1 ->
//     dir_out=0 at the next edge, 2 drain cycles, then port 1 re-arbitrates and wins if alone.
//  5. Port 3 empties after 2 beats -> GRANT lasts 3 cycles (exit on empty), then DRAIN 2, then IDLE.
//  6. reset=1 during GRANT of port 2 -> next cycle all outputs 0 and state IDLE;
//     after release, port 0 wins before port 2 when both request.

Source files
------------

// File: rtl/noc_pkg.sv
// Shared types and default sizing for the crossbar port scheduler and its arbiters.
package noc_pkg;

    localparam int NPORTS_DEF       = 4;
    localparam int MAX_BURST_DEF    = 4;
    localparam int DRAIN_CYCLES_DEF = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        GRANT = 2'd2,
        DRAIN = 2'd3
    } sched_state_t;

endpackage

// File: rtl/xbar_port_scheduler_rr_pick.sv
// Rotating-priority encoder: first set bit of req searching upward from ptr+1, modulo N.
module rr_pick #(
    parameter int N  = 4,
    parameter int PW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [PW-1:0] ptr,
    output logic          found,
    output logic [PW-1:0] idx
);

    logic [PW-1:0] cand;

    always_comb begin
        found = 1'b0;
        idx   = '0;
        cand  = ptr;
        for (int k = 0; k < N; k++) begin
            // Walk ptr+1, ptr+2, ... with explicit wrap so non-power-of-two N works.
            cand = (cand == PW'(N - 1)) ? '0 : cand + PW'(1);
            if (!found && req[cand]) begin
                found = 1'b1;
                idx   = cand;
            end
        end
    end

endmodule

// File: rtl/xbar_port_scheduler.sv
// Round-robin time-sharing of the shared crossbar bus: one sending port per tenure,
// bounded bursts, and a drain gap after each tenure to flush the port read pipeline.
module xbar_port_scheduler
    import noc_pkg::*;
#(
    parameter int NPORTS       = NPORTS_DEF,
    parameter int MAX_BURST    = MAX_BURST_DEF,
    parameter int DRAIN_CYCLES = DRAIN_CYCLES_DEF,
    parameter int IDW          = $clog2(NPORTS)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    input  logic [NPORTS-1:0] in_fifo_empty,
    input  logic              bus_stall,
    output logic [NPORTS-1:0] dir_out,
    output logic              grant_valid,
    output logic [IDW-1:0]    grant_id,
    output logic              busy,
    output logic [15:0]       tenure_cnt
);

    localparam int BW = $clog2(MAX_BURST + 1);
    localparam int DW = $clog2(DRAIN_CYCLES + 1);

    sched_state_t      state_q, state_d;
    logic [IDW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDW-1:0]    grant_id_q, grant_id_d;
    logic [NPORTS-1:0] dir_out_q, dir_out_d;
    logic              grant_valid_q, grant_valid_d;
    logic              busy_q, busy_d;
    logic [15:0]       tenure_cnt_q, tenure_cnt_d;
    logic [BW-1:0]     beat_cnt_q, beat_cnt_d;
    logic [DW-1:0]     drain_cnt_q, drain_cnt_d;

    logic [NPORTS-1:0] req;
    logic              pick_found;
    logic [IDW-1:0]    pick_idx;
    logic              beat;

    assign req  = ~in_fifo_empty;
    assign beat = req[grant_id_q] && !bus_stall;

    rr_pick #(
        .N  (NPORTS),
        .PW (IDW)
    ) u_rr_pick (
        .req   (req),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .idx   (pick_idx)
    );

    always_comb begin
        state_d      = state_q;
        rr_ptr_d     = rr_ptr_q;
        grant_id_d   = grant_id_q;
        dir_out_d    = dir_out_q;
        tenure_cnt_d = tenure_cnt_q;
        beat_cnt_d   = beat_cnt_q;
        drain_cnt_d  = drain_cnt_q;

        case (state_q)
            IDLE: begin
                dir_out_d = '0;
                if (enable && pick_found) begin
                    state_d    = SETUP;
                    grant_id_d = pick_idx;
                    dir_out_d  = NPORTS'(1) << pick_idx;
                end
            end
            SETUP: begin
                state_d    = GRANT;
                beat_cnt_d = '0;
            end
            GRANT: begin
                // A stall or an empty FIFO ends the tenure without counting a beat.
                if (!beat || beat_cnt_q == BW'(MAX_BURST - 1)) begin
                    state_d     = DRAIN;
                    dir_out_d   = '0;
                    drain_cnt_d = '0;
                end else if (beat_cnt_q != BW'(MAX_BURST)) begin
                    beat_cnt_d = beat_cnt_q + BW'(1);
                end
            end
            DRAIN: begin
                dir_out_d = '0;
                if (drain_cnt_q == DW'(DRAIN_CYCLES - 1)) begin
                    state_d      = IDLE;
                    rr_ptr_d     = grant_id_q;
                    tenure_cnt_d = tenure_cnt_q + 16'd1;
                end else begin
                    drain_cnt_d = drain_cnt_q + DW'(1);
                end
            end
            default: begin
                state_d   = IDLE;
                dir_out_d = '0;
            end
        endcase

        grant_valid_d = (state_d == SETUP) || (state_d == GRANT);
        busy_d        = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            rr_ptr_q      <= IDW'(NPORTS - 1);
            grant_id_q    <= '0;
            dir_out_q     <= '0;
            grant_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            tenure_cnt_q  <= '0;
            beat_cnt_q    <= '0;
            drain_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            rr_ptr_q      <= rr_ptr_d;
            grant_id_q    <= grant_id_d;
            dir_out_q     <= dir_out_d;
            grant_valid_q <= grant_valid_d;
            busy_q        <= busy_d;
            tenure_cnt_q  <= tenure_cnt_d;
            beat_cnt_q    <= beat_cnt_d;
            drain_cnt_q   <= drain_cnt_d;
        end
    end

    assign dir_out     = dir_out_q;
    assign grant_valid = grant_valid_q;
    assign grant_id    = grant_id_q;
    assign busy        = busy_q;
    assign tenure_cnt  = tenure_cnt_q;

endmodule

// File: tb/tb_xbar_port_scheduler.sv
// Bench for xbar_port_scheduler: a tenure-level model expands per-port word counts into
// per-cycle stimulus and expected outputs, which are replayed against the DUT.
module tb_xbar_port_scheduler;

    localparam int NP  = 4;
    localparam int MB  = 4;
    localparam int DC  = 2;
    localparam int IDW = 2;
    localparam int OW  = NP + 2 + IDW + 16;
    localparam int SW  = NP + 2;

    logic          clk = 1'b0;
    logic          reset;
    logic          enable;
    logic [NP-1:0] in_fifo_empty;
    logic          bus_stall;
    logic [NP-1:0] dir_out;
    logic          grant_valid;
    logic [IDW-1:0] grant_id;
    logic          busy;
    logic [15:0]   tenure_cnt;

    always #5 clk = ~clk;

    xbar_port_scheduler #(
        .NPORTS       (NP),
        .MAX_BURST    (MB),
        .DRAIN_CYCLES (DC),
        .IDW          (IDW)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .enable        (enable),
        .in_fifo_empty (in_fifo_empty),
        .bus_stall     (bus_stall),
        .dir_out       (dir_out),
        .grant_valid   (grant_valid),
        .grant_id      (grant_id),
        .busy          (busy),
        .tenure_cnt    (tenure_cnt)
    );

    // Scoreboard queues: expected {dir_out, grant_valid, busy, grant_id, tenure_cnt} and
    // matching stimulus {enable, bus_stall, in_fifo_empty} per cycle.
    logic [OW-1:0] exp_q[$];
    logic [SW-1:0] stim_q[$];
    int            seen_q[$];
    int            n_checks = 0;
    int            n_fail   = 0;
    int            cyc      = 0;
    logic          prev_gv  = 1'b0;

    int          m_words[NP];
    int          m_ptr;
    int          m_gid;
    logic [15:0] m_tc;
    int          en_pct, stall_pct, arr_pct, stall_slot;

    function automatic logic chance(input int pct);
        return int'($urandom_range(99)) < pct;
    endfunction

    function automatic void arrive();
        for (int i = 0; i < NP; i++)
            if (chance(arr_pct)) m_words[i]++;
    endfunction

    function automatic void add_cycle(input logic [NP-1:0] dir, input logic gv, input logic bz,
                                      input logic en, input logic st);
        logic [NP-1:0] emp;
        for (int i = 0; i < NP; i++) emp[i] = (m_words[i] == 0);
        stim_q.push_back({en, st, emp});
        exp_q.push_back({dir, gv, bz, IDW'(m_gid), m_tc});
    endfunction

    // Each tenure: one arbitration cycle, one turnaround, grant cycles until the burst
    // limit, a stall or an empty FIFO, then the drain gap.
    function automatic void gen(input int n_ten, input int max_cyc);
        int done  = 0;
        int start = exp_q.size();
        while (done < n_ten && exp_q.size() - start < max_cyc) begin
            int            p;
            int            beats;
            logic          en;
            logic          st;
            logic [NP-1:0] oh;
            arrive();
            en = chance(en_pct);
            p  = -1;
            if (en)
                for (int k = 1; k <= NP; k++)
                    if (p < 0 && m_words[(m_ptr + k) % NP] > 0) p = (m_ptr + k) % NP;
            add_cycle('0, 1'b0, 1'b0, en, chance(stall_pct));
            if (p >= 0) begin
                m_gid = p;
                oh    = '0;
                oh[p] = 1'b1;
                arrive();
                add_cycle(oh, 1'b1, 1'b1, chance(en_pct), chance(stall_pct));
                beats = 0;
                for (int j = 0; j <= MB; j++) begin
                    arrive();
                    st = (stall_slot >= 0) ? (j == stall_slot) : chance(stall_pct);
                    add_cycle(oh, 1'b1, 1'b1, chance(en_pct), st);
                    if (st || m_words[p] == 0) break;
                    m_words[p]--;
                    beats++;
                    if (beats == MB) break;
                end
                for (int d = 0; d < DC; d++) begin
                    arrive();
                    add_cycle('0, 1'b0, 1'b1, chance(en_pct), chance(stall_pct));
                end
                m_ptr = p;
                m_tc++;
                done++;
            end
        end
    endfunction

    task automatic model_reset();
        m_ptr = NP - 1;
        m_gid = 0;
        m_tc  = '0;
        for (int i = 0; i < NP; i++) m_words[i] = 0;
        en_pct     = 100;
        stall_pct  = 0;
        arr_pct    = 0;
        stall_slot = -1;
        exp_q.delete();
        stim_q.delete();
        seen_q.delete();
    endtask

    task automatic do_reset();
        reset         = 1'b1;
        enable        = 1'b1;
        bus_stall     = 1'b0;
        in_fifo_empty = '0;
        repeat (2) @(posedge clk);
        #1;
        reset   = 1'b0;
        prev_gv = 1'b0;
        model_reset();
    endtask

    // Samples the outputs for the current cycle, applies this cycle's inputs, advances one edge.
    task automatic play(input logic [SW-1:0] s, output logic [OW-1:0] obs);
        obs = {dir_out, grant_valid, busy, grant_id, tenure_cnt};
        if (grant_valid && !prev_gv) seen_q.push_back(int'(grant_id));
        prev_gv = grant_valid;
        {enable, bus_stall, in_fifo_empty} = s;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic test_reset();
        logic [OW-1:0] obs, e;
        do_reset();
        n_checks++;
        if ({dir_out, grant_valid, busy, grant_id, tenure_cnt} !== '0) begin
            n_fail++;
            $display("FAIL reset_values got %h exp 0", {dir_out, grant_valid, busy, grant_id, tenure_cnt});
        end
        gen(1, 5);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL reset_idle cyc %0d got %h exp %h", cyc, obs, e); end
        end
    endtask

    task automatic test_single_port();
        logic [OW-1:0] obs, e;
        do_reset();
        m_words[2] = 10;
        gen(3, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL single_port cyc %0d got %h exp %h", cyc, obs, e); end
        end
        n_checks++;
        if (tenure_cnt !== 16'd3) begin
            n_fail++;
            $display("FAIL single_port_tenures got %0d exp 3", tenure_cnt);
        end
    endtask

    task automatic test_three_ports();
        logic [OW-1:0] obs, e;
        int            exp_seq[6] = '{0, 1, 3, 0, 1, 3};
        do_reset();
        m_words[0] = 10;
        m_words[1] = 10;
        m_words[3] = 10;
        gen(6, 200);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL three_ports cyc %0d got %h exp %h", cyc, obs, e); end
        end
        for (int i = 0; i < 6; i++) begin
            n_checks++;
            if (i >= seen_q.size() || seen_q[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL three_ports_order idx %0d got %0d exp %0d", i,
                         (i < seen_q.size()) ? seen_q[i] : -1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic [OW-1:0] obs, e;
        int            exp_seq[3] = '{3, 0, 3};
        do_reset();
        m_words[3] = 1;
        gen(1, 50);
        m_words[0] = 2;
        m_words[3] = 2;
        gen(2, 100);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL wrap cyc %0d got %h exp %h", cyc, obs, e); end
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= seen_q.size() || seen_q[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL wrap_order idx %0d got %0d exp %0d", i,
                         (i < seen_q.size()) ? seen_q[i] : -1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_stall();
        logic [OW-1:0] obs, e;
        do_reset();
        m_words[1] = 10;
        stall_slot = 1;
        gen(1, 50);
        stall_slot = -1;
        gen(1, 50);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL stall cyc %0d got %h exp %h", cyc, obs, e); end
        end
        n_checks++;
        if (seen_q.size() != 2 || seen_q[0] != 1 || seen_q[1] != 1) begin
            n_fail++;
            $display("FAIL stall_rearb got %0d grants exp 2 grants of port 1", seen_q.size());
        end
    endtask

    task automatic test_early_empty();
        logic [OW-1:0] obs, e;
        int            gv_cycles = 0;
        do_reset();
        m_words[3] = 2;
        gen(1, 50);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            if (grant_valid) gv_cycles++;
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL early_empty cyc %0d got %h exp %h", cyc, obs, e); end
        end
        n_checks++;
        if (gv_cycles != 4) begin
            n_fail++;
            $display("FAIL early_empty_len got %0d grant_valid cycles exp 4", gv_cycles);
        end
    endtask

    task automatic test_mid_reset();
        logic [OW-1:0] obs, e;
        int            exp_seq[2] = '{0, 2};
        do_reset();
        m_words[2] = 10;
        gen(1, 50);
        for (int k = 0; k < 4; k++) begin
            e = exp_q.pop_front();
            if (k < 3) begin
                play(stim_q.pop_front(), obs);
            end else begin
                obs           = {dir_out, grant_valid, busy, grant_id, tenure_cnt};
                reset         = 1'b1;
                in_fifo_empty = 4'b1010;
                @(posedge clk);
                #1;
            end
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL mid_reset_pre cyc %0d got %h exp %h", k, obs, e); end
        end
        n_checks++;
        if ({dir_out, grant_valid, busy, grant_id, tenure_cnt} !== '0) begin
            n_fail++;
            $display("FAIL mid_reset_clear got %h exp 0", {dir_out, grant_valid, busy, grant_id, tenure_cnt});
        end
        reset   = 1'b0;
        prev_gv = 1'b0;
        model_reset();
        m_words[0] = 3;
        m_words[2] = 9;
        gen(2, 60);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            play(stim_q.pop_front(), obs);
            n_checks++;
            if (obs !== e) begin n_fail++; $display("FAIL mid_reset_post cyc %0d got %h exp %h", cyc, obs, e); end
        end
        for (int i = 0; i < 2; i++) begin
            n_checks++;
            if (i >= seen_q.size() || seen_q[i] != exp_seq[i]) begin
                n_fail++;
                $display("FAIL mid_reset_order idx %0d got %0d exp %0d", i,
                         (i < seen_q.size()) ? seen_q[i] : -1, exp_seq[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [OW-1:0] obs, e;
        for (int r = 0; r < 3; r++) begin
            do_reset();
            for (int i = 0; i < NP; i++) m_words[i] = int'($urandom_range(6));
            arr_pct   = 15;
            stall_pct = 10;
            en_pct    = 80;
            gen(30, 600);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                play(stim_q.pop_front(), obs);
                n_checks++;
                if (obs !== e) begin n_fail++; $display("FAIL random run %0d cyc %0d got %h exp %h", r, cyc, obs, e); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_port();
        test_three_ports();
        test_wrap();
        test_stall();
        test_early_empty();
        test_mid_reset();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
